fifo_pkt_arbiter: RTL and testbench

Packet-granular round-robin arbiter sharing one `fifo` write port among `pREQ` requesters. Once a requester is granted, it owns the FIFO until it delivers a word flagged last, or hits the length limit. Words are steered combinationally to the FIFO write port, and FIFO full back-pressures the owner. Sits between the packet sources and the shared `fifo` instance in the copy-memory datapath.

---
 rtl/fifo_arb_pkg.sv | 11 +
 rtl/fifo_pkt_arbiter_rr_pick.sv | 23 ++
 rtl/fifo_pkt_arbiter.sv | 79 +++++++
 tb/tb_fifo_pkt_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and sizing helper for the packet arbiter
package fifo_arb_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   // Bits needed to hold values 0..n-1, never less than one
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_pkt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request above irr with wrap
//   ireq   : request vector
//   irr    : index of the previous winner
//   ofound : any request set
//   oidx   : winning index
module rr_pick #(
   parameter int pREQ = 4,
   parameter int pIW  = 2
) (
   input  logic [pREQ-1:0] ireq,
   input  logic [pIW-1:0]  irr,
   output logic            ofound,
   output logic [pIW-1:0]  oidx
);
   // Lowest set bit overall is the wrap-around fallback; the lowest set bit
   // strictly above irr overrides it, so no modulo arithmetic is needed.
   always_comb begin
      ofound = |ireq;
      oidx = '0;
      for (int i = pREQ - 1; i >= 0; i--) if (ireq[i]) oidx = pIW'(i);
      for (int i = pREQ - 1; i >= 0; i--) if (ireq[i] && pIW'(i) > irr) oidx = pIW'(i);
   end
endmodule

// File: rtl/fifo_pkt_arbiter.sv
// fifo_pkt_arbiter: packet-granular round-robin sharing of one fifo write port
//   iclk/ireset          : clock, synchronous active-high reset
//   ireq/ilast/idata     : per-requester valid, last flag and word
//   oack                 : one-hot accept of the owner's word
//   ogrant/obusy         : registered owner (one-hot) and busy state
//   ifull                : fifo full, back-pressures the owner
//   ofifo_wr/ofifo_data  : fifo write port
//   oerr/oerr_id         : truncation pulse at pMAX_LEN and offending requester
module fifo_pkt_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int pBITS    = 8,
   parameter int pREQ     = 4,
   parameter int pMAX_LEN = 64
) (
   input  logic                      iclk,
   input  logic                      ireset,
   input  logic [pREQ-1:0]           ireq,
   input  logic [pREQ-1:0]           ilast,
   input  logic [pREQ*pBITS-1:0]     idata,
   output logic [pREQ-1:0]           oack,
   output logic [pREQ-1:0]           ogrant,
   input  logic                      ifull,
   output logic                      ofifo_wr,
   output logic [pBITS-1:0]          ofifo_data,
   output logic                      obusy,
   output logic                      oerr,
   output logic [clog2(pREQ)-1:0]    oerr_id
);
   localparam int IW = clog2(pREQ);
   localparam int LW = clog2(pMAX_LEN + 1);
   state_t           r_state;
   logic [IW-1:0]    r_grant, r_rr, w_pick;
   logic [LW-1:0]    r_len;
   logic             w_busy, w_found, w_wr, w_last, w_lim, w_err;
   logic [pBITS-1:0] w_words [pREQ];
   for (genvar g = 0; g < pREQ; g++) begin : g_words
      assign w_words[g] = idata[g*pBITS +: pBITS];
   end
   rr_pick #(.pREQ(pREQ), .pIW(IW)) u_pick (
      .ireq   (ireq),
      .irr    (r_rr),
      .ofound (w_found),
      .oidx   (w_pick)
   );
   assign w_busy     = r_state == BUSY;
   assign w_wr       = w_busy & ireq[r_grant] & ~ifull;
   assign w_last     = ilast[r_grant];
   assign w_lim      = (r_len + LW'(1)) == LW'(pMAX_LEN);
   assign w_err      = w_wr & ~w_last & w_lim;
   assign ofifo_wr   = w_wr;
   assign oack       = w_wr ? pREQ'(1) << r_grant : '0;
   assign ogrant     = w_busy ? pREQ'(1) << r_grant : '0;
   assign obusy      = w_busy;
   assign ofifo_data = w_busy ? w_words[r_grant] : '0;
   assign oerr       = w_err;
   assign oerr_id    = w_err ? r_grant : '0;
   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_rr    <= IW'(pREQ - 1);
         r_len   <= '0;
      end else if (!w_busy) begin
         if (w_found) begin
            r_state <= BUSY;
            r_grant <= w_pick;
            r_len   <= '0;
         end
      end else if (w_wr) begin
         r_len <= r_len + LW'(1);
         // A last word or the length limit both close the packet
         if (w_last || w_lim) begin
            r_state <= IDLE;
            r_rr    <= r_grant;
         end
      end
   end
endmodule

// File: tb/tb_fifo_pkt_arbiter.sv
// tb_fifo_pkt_arbiter: scoreboard bench with packet-level reference model
module tb_fifo_pkt_arbiter;
   localparam int BITS = 8;
   localparam int REQ  = 4;
   localparam int MAX  = 4;
   typedef struct {logic [7:0] d; logic last;} word_t;
   typedef struct {logic [7:0] d; logic [3:0] ack; logic err; logic [1:0] id;} exp_t;
   logic clk = 0, rst = 1;
   logic [3:0] ireq = '0, ilast = '0;
   logic [31:0] idata = '0;
   logic [3:0] oack, ogrant;
   logic ifull = 0, ofifo_wr, obusy, oerr;
   logic [7:0] ofifo_data;
   logic [1:0] oerr_id;
   logic [7:0] dw [4];
   word_t rq [4][$];
   exp_t sb [$];
   logic [3:0] glog [$];
   logic [3:0] prev_grant = '0;
   int m_own = -1, m_last = REQ - 1, m_len = 0;
   int full_cnt = 0, stall2_cnt = 0, n_err_seen = 0;
   int ack_cnt [4] = '{0, 0, 0, 0};
   bit rnd = 0, rst_drv = 1, chk_en = 0;
   int n_cmp = 0, n_bad = 0;

   fifo_pkt_arbiter #(.pBITS(BITS), .pREQ(REQ), .pMAX_LEN(MAX)) dut (
      .iclk(clk), .ireset(rst), .ireq(ireq), .ilast(ilast), .idata(idata),
      .oack(oack), .ogrant(ogrant), .ifull(ifull), .ofifo_wr(ofifo_wr),
      .ofifo_data(ofifo_data), .obusy(obusy), .oerr(oerr), .oerr_id(oerr_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic add_pkt(input int r, input int len, input bit with_last);
      word_t w;
      for (int k = 0; k < len; k++) begin
         w.d = 8'($urandom);
         w.last = with_last && (k == len - 1);
         rq[r].push_back(w);
      end
   endtask

   function automatic bit qempty();
      for (int i = 0; i < REQ; i++) if (rq[i].size() != 0) return 0;
      return 1;
   endfunction

   // Reference: idle picks the next requester after the previous owner (mod REQ);
   // the owner streams words until one carries last or MAX words have gone.
   task automatic model();
      exp_t e;
      bit acc;
      int j;
      if (chk_en) begin
         chk("obusy", 32'(obusy), 32'(m_own >= 0));
         chk("ogrant", 32'(ogrant), m_own >= 0 ? 32'(1) << m_own : 32'(0));
         if (m_own < 0) begin
            chk("idle_wr", 32'(ofifo_wr), 0);
            chk("idle_data", 32'(ofifo_data), 0);
            chk("idle_ack", 32'(oack), 0);
         end
      end
      acc = m_own >= 0 && ireq[m_own] && !ifull;
      if (acc) begin
         e.d = dw[m_own];
         e.ack = 4'(1 << m_own);
         e.err = !ilast[m_own] && (m_len + 1 == MAX);
         e.id = 2'(m_own);
         sb.push_back(e);
      end
      if (rst) begin
         m_own = -1;
         m_last = REQ - 1;
         m_len = 0;
      end else if (m_own < 0) begin
         for (int k = 1; k <= REQ; k++) begin
            j = (m_last + k) % REQ;
            if (ireq[j]) begin
               m_own = j;
               m_len = 0;
               break;
            end
         end
      end else if (acc) begin
         m_len++;
         if (ilast[m_own] || m_len == MAX) begin
            m_last = m_own;
            m_own = -1;
         end
      end
   endtask

   task automatic step();
      bit st;
      @(posedge clk);
      #1;
      rst = rst_drv;
      ifull = (full_cnt > 0) || (rnd && $urandom_range(0, 4) == 0);
      if (full_cnt > 0) full_cnt--;
      for (int i = 0; i < REQ; i++) begin
         st = (i == 2 && stall2_cnt > 0) || (rnd && $urandom_range(0, 3) == 0);
         ireq[i] = rq[i].size() > 0 && !st;
         dw[i] = rq[i].size() > 0 ? rq[i][0].d : 8'($urandom);
         ilast[i] = rq[i].size() > 0 ? rq[i][0].last : 1'($urandom);
      end
      if (stall2_cnt > 0) stall2_cnt--;
      idata = {dw[3], dw[2], dw[1], dw[0]};
      #4;
      model();
      for (int i = 0; i < REQ; i++) if (oack[i] === 1'b1) begin
         ack_cnt[i]++;
         if (rq[i].size() > 0) void'(rq[i].pop_front());
      end
      if (ogrant !== 4'b0 && prev_grant === 4'b0) glog.push_back(ogrant);
      prev_grant = ogrant;
      if (oerr === 1'b1) n_err_seen++;
   endtask

   task automatic do_reset();
      rst_drv = 1;
      step();
      rst_drv = 0;
   endtask

   task automatic drain(input string nm, input int budget);
      int n;
      n = 0;
      while (!(qempty() && m_own < 0) && n < budget) begin
         step();
         n++;
      end
      chk(nm, 32'(n < budget), 1);
   endtask

   task automatic wait_acks(input string nm, input int r, input int target);
      int n;
      n = 0;
      while (ack_cnt[r] < target && n < 30) begin
         step();
         n++;
      end
      chk(nm, 32'(ack_cnt[r] >= target), 1);
   endtask

   // Monitor: every DUT write pops one expected word; a model write the DUT missed is a failure
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (chk_en) begin
         if (ofifo_wr === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_write: got data %0h expected no write", ofifo_data);
            end else begin
               e = sb.pop_front();
               chk("wr_data", 32'(ofifo_data), 32'(e.d));
               chk("wr_ack", 32'(oack), 32'(e.ack));
               chk("wr_err", 32'(oerr), 32'(e.err));
               if (e.err) chk("wr_err_id", 32'(oerr_id), 32'(e.id));
            end
         end else begin
            chk("nowr_ack", 32'(oack), 0);
            chk("nowr_err", 32'(oerr), 0);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_write: got no write expected data %0h", e.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] exp_ord [5];
      int a;
      exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      chk_en = 1;
      step();
      chk("rst_grant", 32'(ogrant), 0);
      chk("rst_busy", 32'(obusy), 0);
      chk("rst_err", 32'(oerr), 0);
      chk("rst_err_id", 32'(oerr_id), 0);
      chk("rst_wr", 32'(ofifo_wr), 0);
      chk("rst_ack", 32'(oack), 0);
      chk("rst_data", 32'(ofifo_data), 0);
      // Single 3-word packet from requester 0
      add_pkt(0, 3, 1);
      drain("t1_done", 20);
      chk("t1_acks", 32'(ack_cnt[0]), 3);
      // Everyone requesting, one-word packets: 0,1,2,3,0
      do_reset();
      glog.delete();
      add_pkt(0, 1, 1);
      add_pkt(0, 1, 1);
      for (int i = 1; i < REQ; i++) add_pkt(i, 1, 1);
      drain("t2_done", 40);
      chk("t2_grants", 32'(glog.size()), 5);
      for (int i = 0; i < 5 && i < glog.size(); i++) chk("t2_order", 32'(glog[i]), 32'(exp_ord[i]));
      // FIFO full for 5 cycles mid-packet
      a = ack_cnt[1];
      add_pkt(1, 5, 1);
      wait_acks("t3_start", 1, a + 2);
      full_cnt = 5;
      a = ack_cnt[1];
      repeat (5) step();
      chk("t3_hold_ack", 32'(ack_cnt[1]), 32'(a));
      chk("t3_hold_grant", 32'(ogrant), 32'b0010);
      drain("t3_done", 30);
      // Owner 2 stalls while requester 1 waits
      a = ack_cnt[2];
      add_pkt(2, 6, 1);
      wait_acks("t4_start", 2, a + 1);
      add_pkt(1, 2, 1);
      stall2_cnt = 4;
      a = ack_cnt[1];
      repeat (4) step();
      chk("t4_no_ack1", 32'(ack_cnt[1]), 32'(a));
      chk("t4_grant", 32'(ogrant), 32'b0100);
      drain("t4_done", 30);
      // Truncation at MAX words on a stream with no last flag
      a = ack_cnt[3];
      n_err_seen = 0;
      add_pkt(3, 6, 0);
      repeat (14) step();
      chk("t5_err_count", 32'(n_err_seen), 1);
      chk("t5_acks", 32'(ack_cnt[3] - a), 6);
      chk("t5_grant_held", 32'(ogrant), 32'b1000);
      // Reset after 2 of 5 words
      do_reset();
      a = ack_cnt[2];
      add_pkt(2, 5, 1);
      wait_acks("t6_start", 2, a + 2);
      add_pkt(1, 2, 1);
      add_pkt(3, 1, 1);
      do_reset();
      step();
      chk("t6_rst_grant", 32'(ogrant), 0);
      chk("t6_rst_busy", 32'(obusy), 0);
      chk("t6_rst_wr", 32'(ofifo_wr), 0);
      step();
      chk("t6_next_grant", 32'(ogrant), 32'b0010);
      drain("t6_done", 60);
      // Randomised traffic with random full and stalls
      rnd = 1;
      repeat (400) begin
         int r;
         step();
         r = $urandom_range(0, REQ - 1);
         if ($urandom_range(0, 2) == 0 && rq[r].size() < 8) add_pkt(r, $urandom_range(1, 7), 1);
      end
      rnd = 0;
      drain("t7_done", 500);
      repeat (3) step();
      chk("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
